// File: rtl/dac_pkg.sv
// Shared constants for the PWM audio DAC: code width, midscale, gain range
// and the mute/ramp state encoding.
package dac_pkg;

    localparam int CODE_WIDTH = 10;
    localparam logic [CODE_WIDTH-1:0] MID_CODE = CODE_WIDTH'(1 << (CODE_WIDTH - 1));

    // Gain is a 5-bit value in 0..16, applied as (diff * g) >>> 4
    localparam int GAIN_WIDTH = 5;
    localparam int GAIN_MAX   = 16;
    localparam int GAIN_SHIFT = 4;

    localparam logic [1:0] ST_MUTED     = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

endpackage

// File: rtl/dac_gain.sv
// Combinational gain scaler: scales an offset-binary code around midscale by
// g/16. The arithmetic shift floors toward minus infinity, and with g <= 16
// the result always lands back inside the unsigned code range.
module dac_gain #(
    parameter int CODE_WIDTH = dac_pkg::CODE_WIDTH
) (
    input  logic [CODE_WIDTH-1:0]          active_code,
    input  logic [dac_pkg::GAIN_WIDTH-1:0] g,
    output logic [CODE_WIDTH-1:0]          eff_code_next
);

    localparam int PW = CODE_WIDTH + dac_pkg::GAIN_WIDTH + 2;
    localparam logic [CODE_WIDTH-1:0] MID = CODE_WIDTH'(1 << (CODE_WIDTH - 1));

    logic signed [CODE_WIDTH:0] diff;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       scaled;

    // Signed offset from midscale, scaled by g, then shifted back onto midscale
    always_comb begin
        diff          = $signed({1'b0, active_code}) - $signed({1'b0, MID});
        prod          = PW'(diff) * PW'($signed({1'b0, g}));
        scaled        = prod >>> dac_pkg::GAIN_SHIFT;
        eff_code_next = CODE_WIDTH'(scaled + PW'($signed({1'b0, MID})));
    end

endmodule

// File: rtl/pwm_dac.sv
// PWM audio DAC with windowed sample loading and mute control.
// Every CYCLES_PER_WINDOW clocks the block requests a sample, loads it, and
// produces a PWM window whose high time equals the gain-scaled code.
// Build option PWM_DAC_SOFT_MUTE_EN: when defined, mute/unmute ramps the gain
// one step per window; when undefined, gain jumps directly between 0 and 16.
module pwm_dac #(
    parameter int CODE_WIDTH        = dac_pkg::CODE_WIDTH,
    parameter int CYCLES_PER_WINDOW = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_WIDTH-1:0] code,
    input  logic                  enable,
    output logic                  next_sample,
    output logic                  pwm,
    output logic                  muted
);

    localparam int CNT_W = (CYCLES_PER_WINDOW > 1) ? $clog2(CYCLES_PER_WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_WINDOW - 1);
    localparam logic [CODE_WIDTH-1:0] MID = CODE_WIDTH'(1 << (CODE_WIDTH - 1));
    localparam int GW = dac_pkg::GAIN_WIDTH;
    localparam logic [GW-1:0] G_MAX = GW'(dac_pkg::GAIN_MAX);

    logic [CNT_W-1:0]      cnt;
    logic [CODE_WIDTH-1:0] active_code, active_code_d;
    logic [CODE_WIDTH-1:0] eff_code, eff_code_next;
    logic [GW-1:0]         g, g_d;
    logic [1:0]            state, state_d;
    logic                  boundary;

    assign boundary = (cnt == CNT_LAST);

    // Next gain/state, only consulted on the boundary edge
    always_comb begin
        state_d = state;
        g_d     = g;
`ifdef PWM_DAC_SOFT_MUTE_EN
        case (state)
            dac_pkg::ST_MUTED: begin
                if (enable) begin
                    state_d = dac_pkg::ST_RAMP_UP;
                    g_d     = GW'(1);
                end else begin
                    g_d = '0;
                end
            end
            dac_pkg::ST_RAMP_UP: begin
                if (enable) begin
                    g_d     = g + GW'(1);
                    state_d = (g_d == G_MAX) ? dac_pkg::ST_RUN : dac_pkg::ST_RAMP_UP;
                end else begin
                    g_d     = g - GW'(1);
                    state_d = (g_d == '0) ? dac_pkg::ST_MUTED : dac_pkg::ST_RAMP_DOWN;
                end
            end
            dac_pkg::ST_RUN: begin
                if (!enable) begin
                    state_d = dac_pkg::ST_RAMP_DOWN;
                    g_d     = G_MAX - GW'(1);
                end
            end
            dac_pkg::ST_RAMP_DOWN: begin
                if (enable) begin
                    g_d     = g + GW'(1);
                    state_d = (g_d == G_MAX) ? dac_pkg::ST_RUN : dac_pkg::ST_RAMP_UP;
                end else begin
                    g_d     = g - GW'(1);
                    state_d = (g_d == '0) ? dac_pkg::ST_MUTED : dac_pkg::ST_RAMP_DOWN;
                end
            end
            default: begin
                state_d = dac_pkg::ST_MUTED;
                g_d     = '0;
            end
        endcase
`else
        case (state)
            dac_pkg::ST_MUTED: begin
                if (enable) begin
                    state_d = dac_pkg::ST_RUN;
                    g_d     = G_MAX;
                end else begin
                    g_d = '0;
                end
            end
            dac_pkg::ST_RUN: begin
                if (!enable) begin
                    state_d = dac_pkg::ST_MUTED;
                    g_d     = '0;
                end
            end
            default: begin
                state_d = dac_pkg::ST_MUTED;
                g_d     = '0;
            end
        endcase
`endif
    end

    // The sample taken at the boundary feeds the scaler directly, so it is
    // heard in the very next window
    always_comb begin
        active_code_d = boundary ? code : active_code;
    end

    dac_gain #(
        .CODE_WIDTH(CODE_WIDTH)
    ) u_gain (
        .active_code  (active_code_d),
        .g            (g_d),
        .eff_code_next(eff_code_next)
    );

    // Window counter plus per-window registers updated on the boundary edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            active_code <= MID;
            eff_code    <= MID;
            g           <= '0;
            state       <= dac_pkg::ST_MUTED;
        end else begin
            cnt <= boundary ? '0 : cnt + CNT_W'(1);
            if (boundary) begin
                active_code <= active_code_d;
                eff_code    <= eff_code_next;
                g           <= g_d;
                state       <= state_d;
            end
        end
    end

    // Outputs are gated by rst so they drop at once, not at the next edge
    always_comb begin
        next_sample = boundary && !rst;
        pwm         = !rst && (32'(cnt) < 32'(eff_code));
        muted       = (state == dac_pkg::ST_MUTED);
    end

endmodule
